fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_queue.sv | 87 ++++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch front end.
// Contents:
//   XLEN          - machine word width (32)
//   NOP           - canonical RV32I no-op (addi x0, x0, 0)
//   fetch_state_e - fetch sequencer states BOOT / RUN / HALT
//   fetch_entry_t - fetch queue entry {pc, instr}
//   word_align    - clears the two byte-offset bits of an address
//   low_bits_set  - flags an address that is not word aligned
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   function automatic logic low_bits_set(input logic [XLEN-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side handshake between the fetch unit and its consumer.
// Signals:
//   fetch_valid_o       - queue head holds a valid instruction (fetch -> decode)
//   fetch_ready_i       - decode accepts the head entry       (decode -> fetch)
//   fetch_instruction_o - instruction word of the head entry  (fetch -> decode)
//   fetch_pc_o          - PC of the head entry                (fetch -> decode)
// Modports: master (fetch unit side), slave (decode side).
interface fetch_unit_if;
   import rv32i_pkg::*;

   logic            fetch_valid_o;
   logic            fetch_ready_i;
   logic [XLEN-1:0] fetch_instruction_o;
   logic [XLEN-1:0] fetch_pc_o;

   modport master (
      output fetch_valid_o,
      output fetch_instruction_o,
      output fetch_pc_o,
      input  fetch_ready_i
   );

   modport slave (
      input  fetch_valid_o,
      input  fetch_instruction_o,
      input  fetch_pc_o,
      output fetch_ready_i
   );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (control state only)
//   flush      - empties the queue; wins over push and pop
//   push       - write wr_entry (taken when not full, or when full with a pop)
//   pop        - retire the head entry (ignored when empty)
//   wr_entry   - entry to write
//   head       - oldest entry (raw storage; only meaningful when !empty)
//   full/empty - occupancy flags
// DEPTH must be 2 or 4, so pointers wrap naturally at their width.
module fetch_queue
   import rv32i_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int unsigned    PW         = (DEPTH > 2) ? 2 : 1;
   localparam int unsigned    CW         = PW + 1;
   localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

   fetch_entry_t  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   // Qualify requests against occupancy; a full queue accepts a push only alongside a pop.
   always_comb begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
      if (flush) begin
         pop_ok_s  = 1'b0;
         push_ok_s = 1'b0;
      end else begin
         pop_ok_s  = pop && (count_r != {CW{1'b0}});
         push_ok_s = push && ((count_r != FULL_COUNT) || pop_ok_s);
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; data needs no reset because occupancy gates its use.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_entry;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == FULL_COUNT);
   assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequences the fetch PC, reads instruction memory
// combinationally and buffers {pc, instr} pairs for decode.
// Parameters:
//   RESET_PC - first fetch address after reset (word aligned)
//   QDEPTH   - fetch queue depth, 2 or 4
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   instruction_address_o  - current fetch address (pc)
//   instruction_data_i     - memory word at instruction_address_o, same cycle
//   redirect_valid_i/pc_i  - branch/jump redirect; flushes the queue
//   halt_i                 - stop issuing new fetches (queue still drains)
//   fetch                  - decode handshake (fetch_unit_if master)
//   misaligned_o           - one-cycle pulse after a non-word-aligned redirect
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic [XLEN-1:0] instruction_address_o,
   input  logic [XLEN-1:0] instruction_data_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            halt_i,
   fetch_unit_if.master    fetch,
   output logic            misaligned_o
);

   fetch_state_e    state_r;
   logic [XLEN-1:0] pc_r;
   logic            misaligned_r;
   logic            push_s;
   logic            pop_s;
   logic            full_s;
   logic            empty_s;
   fetch_entry_t    wr_entry_s;
   fetch_entry_t    head_s;

   // Push/pop decisions. A redirect flushes the queue, so neither is credited that cycle.
   always_comb begin
      pop_s            = 1'b0;
      push_s           = 1'b0;
      wr_entry_s.pc    = pc_r;
      wr_entry_s.instr = instruction_data_i;
      if (redirect_valid_i) begin
         pop_s  = 1'b0;
         push_s = 1'b0;
      end else begin
         pop_s  = !empty_s && fetch.fetch_ready_i;
         push_s = (state_r == RUN) && (!full_s || pop_s);
      end
   end

   fetch_queue #(
      .DEPTH    (QDEPTH)
   ) u_queue (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .flush    (redirect_valid_i),
      .push     (push_s),
      .pop      (pop_s),
      .wr_entry (wr_entry_s),
      .head     (head_s),
      .full     (full_s),
      .empty    (empty_s)
   );

   // Fetch sequencer, fetch PC and misaligned-redirect flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= BOOT;
         pc_r         <= RESET_PC;
         misaligned_r <= 1'b0;
      end else begin
         misaligned_r <= redirect_valid_i && low_bits_set(redirect_pc_i);
         if (redirect_valid_i) begin
            // Redirect only retargets the PC; the sequencer holds its state.
            pc_r    <= word_align(redirect_pc_i);
            state_r <= state_r;
         end else begin
            if (push_s) begin
               pc_r <= pc_r + 32'd4;
            end
            // The state reached here governs pushes from the next cycle on.
            case (state_r)
               BOOT:    state_r <= RUN;
               RUN:     state_r <= halt_i ? HALT : RUN;
               HALT:    state_r <= halt_i ? HALT : RUN;
               default: state_r <= BOOT;
            endcase
         end
      end
   end

   assign instruction_address_o     = pc_r;
   assign misaligned_o              = misaligned_r;
   assign fetch.fetch_valid_o       = !empty_s;
   // Head outputs read as zero while empty, so unreset storage never leaks out.
   assign fetch.fetch_pc_o          = empty_s ? {XLEN{1'b0}} : head_s.pc;
   assign fetch.fetch_instruction_o = empty_s ? {XLEN{1'b0}} : head_s.instr;

endmodule
